// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux slice: mode encodings and select-width helper.
// No logic, no latency.
// No flow control lives here.
package stream_mux_pkg;

  // Runtime mode encodings
  localparam logic MODE_SEL = 1'b0;  // explicit channel select
  localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

  // Ceiling log2 of n, never less than 1, so a 1-bit select still exists for tiny N.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; the caller qualifies the grant with its own load enable.
//
// Ports:
//   req     - per-channel request, bit i = channel i
//   ptr     - last granted channel; the search starts at ptr+1 (must be < N)
//   gnt     - one-hot grant, zero when nothing requests
//   gnt_idx - encoded index of gnt (0 when no grant)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Each channel's distance from the search start is (i - ptr - 1) mod N;
  // the requester with the smallest distance wins. Walking channels with a
  // constant loop index keeps every bit select static.
  always_comb begin
    int best_d;
    int d;
    gnt     = '0;
    gnt_idx = '0;
    best_d  = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(ptr)) % N;
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N:1 stream multiplexer with per-channel valid/ready, explicit-select or round-robin mode.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: out_valid && !out_ready holds the output register and drops every in_ready.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   mux_in              - packed channels, channel i at [(N-1-i)*W +: W] (channel 0 in MSBs)
//   in_valid / in_ready - per-channel handshake; in_ready is one-hot or zero
//   mode, sel           - 0: take channel sel; 1: round-robin over valid channels
//   mux_out, out_sel    - registered data word and its source channel
//   out_valid/out_ready - output handshake
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   mux_in,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     mux_out,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     mux_out_q,   mux_out_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     sel_gnt;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_dat;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(
    .N  (N),
    .PW (SEL_W)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Grant selection and the data of the granted channel. A sel value >= N
  // matches no channel, so it simply yields no grant.
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if ((sel == SEL_W'(i)) && in_valid[i]) sel_gnt[i] = 1'b1;
    end
    gnt     = (mode == MODE_RR) ? rr_gnt : sel_gnt;
    gnt_idx = '0;
    gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx = SEL_W'(i);
        gnt_dat = mux_in[(N-1-i)*W +: W];
      end
    end
  end

  // Output slot can take a word when empty or being drained this cycle.
  // rst_n gates in_ready so nothing is offered while reset is held.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = (load_en && rst_n) ? gnt : '0;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    mux_out_d   = mux_out_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      mux_out_d   = gnt_dat;
      out_sel_d   = gnt_idx;
      if (mode == MODE_RR) ptr_d = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so the first round-robin search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mux_out_q   <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SEL_W'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      mux_out_q   <= mux_out_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mux_out   = mux_out_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] mux_in;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  mux_out;
  logic [SW-1:0] out_sel;
  logic          out_valid;
  logic          out_ready;

  logic [W-1:0]  ch_dat [N];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the single output slot plus the round-robin pointer.
  int m_valid, m_data, m_sel, m_ptr;
  int q_dat[$];
  int q_tag[$];

  always #5 clk = ~clk;

  always_comb begin
    mux_in = '0;
    for (int i = 0; i < N; i++) mux_in[(N-1-i)*W +: W] = ch_dat[i];
  end

  stream_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mux_in    (mux_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = N - 1;
    q_dat.delete();
    q_tag.delete();
  endtask

  // Channel the specification says should be granted now, or -1.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: inputs were set at the preceding negedge.
  task automatic step(input string tag);
    int g;
    int exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (rst_n && g >= 0 && (m_valid == 0 || out_ready)) ? (1 << g) : 0;
    check({tag, "_rdy"}, 32'(in_ready), exp_rdy);
    if (rst_n && out_valid && out_ready) begin
      check({tag, "_sb_pending"}, (q_dat.size() != 0) ? 1 : 0, 1);
      if (q_dat.size() != 0) begin
        check({tag, "_sb_dat"}, 32'(mux_out), q_dat.pop_front());
        check({tag, "_sb_tag"}, 32'(out_sel), q_tag.pop_front());
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (exp_rdy != 0) begin
      m_valid = 1;
      m_data  = ch_dat[g];
      m_sel   = g;
      if (mode) m_ptr = g;
      q_dat.push_back(ch_dat[g]);
      q_tag.push_back(g);
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    #1;
    check({tag, "_ovld"}, 32'(out_valid), m_valid);
    check({tag, "_odat"}, 32'(mux_out), m_data);
    check({tag, "_osel"}, 32'(out_sel), m_sel);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ovld", 32'(out_valid), 0);
    check("rst_rdy", 32'(in_ready), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_s[5];
    int exp_d[5];
    int exp_skip[4];
    exp_s = '{0, 1, 2, 3, 0};
    exp_d = '{1, 11, 3, 5, 1};
    exp_skip = '{2, 3, 0, 2};

    ch_dat[0] = 8'd1; ch_dat[1] = 8'd11; ch_dat[2] = 8'd3; ch_dat[3] = 8'd5;
    in_valid  = '1;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("reset_ovld", 32'(out_valid), 0);
    check("reset_odat", 32'(mux_out), 0);
    check("reset_osel", 32'(out_sel), 0);
    check("reset_rdy", 32'(in_ready), 0);
    step("in_reset");
    rst_n = 1'b1;

    // SEL mode, back-to-back select changes
    sel = 2'd2;
    #1 check("sel2_rdy", 32'(in_ready), 32'b0100);
    step("sel2");
    check("sel2_dat", 32'(mux_out), 3);
    check("sel2_tag", 32'(out_sel), 2);
    sel = 2'd1;
    step("sel1");
    check("sel1_dat", 32'(mux_out), 11);
    sel = 2'd3;
    in_valid[3] = 1'b0;
    #1 check("sel3_norq_rdy", 32'(in_ready), 0);
    step("sel3");
    check("sel3_drained", 32'(out_valid), 0);
    check("sel3_hold_dat", 32'(mux_out), 11);

    // Round-robin from reset, then skip a channel
    in_valid = '1;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      check("rr_seq_tag", 32'(out_sel), exp_s[i]);
      check("rr_seq_dat", 32'(mux_out), exp_d[i]);
    end
    in_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("rr_skip");
      check("rr_skip_tag", 32'(out_sel), exp_skip[i]);
    end

    // Backpressure
    in_valid = '1;
    do_reset();
    step("bp_first");
    check("bp_first_dat", 32'(mux_out), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_stall_rdy", 32'(in_ready), 0);
      step("bp_stall");
      check("bp_stall_dat", 32'(mux_out), 1);
    end
    out_ready = 1'b1;
    step("bp_release");
    check("bp_release_dat", 32'(mux_out), 11);
    check("bp_release_tag", 32'(out_sel), 1);

    // Reset mid-stream (asynchronous)
    rst_n = 1'b0;
    #1;
    check("mid_rst_ovld", 32'(out_valid), 0);
    check("mid_rst_rdy", 32'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst_tag", 32'(out_sel), 0);

    // Randomised traffic against the model and scoreboard
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) ch_dat[c] = W'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = SW'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
